wb_timer_mc: RTL

WB_TIMER_MC -- requirements
Module: wb_timer_mc

---
 rtl/wb_timer_mc.sv | 138 +++++++++++++
 1 files changed

// File: rtl/wb_timer_mc.sv
// rtl/wb_timer_mc.sv - Wishbone multi-channel compare timer with shared prescaler
module wb_timer_mc #(
  parameter int WB_DATA_WIDTH = 32,
  parameter int WB_ADDR_WIDTH = 32,
  parameter int WB_SEL_WIDTH  = 4,
  parameter int NUM_CH        = 4,
  parameter int CNT_WIDTH     = 32,
  parameter int PRE_WIDTH     = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [WB_ADDR_WIDTH-1:0] wb_addr_i,
  input  logic [WB_DATA_WIDTH-1:0] wb_data_i,
  input  logic                     wb_we_i,
  input  logic [WB_SEL_WIDTH-1:0]  wb_sel_i,
  input  logic                     wb_stb_i,
  input  logic                     wb_cyc_i,
  output logic                     wb_ack_o,
  output logic [WB_DATA_WIDTH-1:0] wb_data_o,
  output logic [NUM_CH-1:0]        ch_irq_o,
  output logic                     timer_irq_o
);

  logic [PRE_WIDTH-1:0]     prescale, pcnt, pre_m;
  logic [CNT_WIDTH-1:0]     cmp    [NUM_CH];
  logic [CNT_WIDTH-1:0]     cnt    [NUM_CH];
  logic [CNT_WIDTH-1:0]     cnt_hw [NUM_CH];
  logic [CNT_WIDTH-1:0]     cmp_m  [NUM_CH];
  logic [CNT_WIDTH-1:0]     cnt_m  [NUM_CH];
  logic [NUM_CH-1:0]        en, periodic, ie, pend;
  logic [NUM_CH-1:0]        match, en_hw, clr;
  logic [NUM_CH-1:0]        wr_ctrl, wr_cmp, wr_cnt;
  logic [5:0]               widx;
  logic [3:0]               grp, ch_idx;
  logic [1:0]               sub;
  logic                     ch_ok, access, wr, wr_pre, wr_status, tick;
  logic [WB_DATA_WIDTH-1:0] wmask, rdata;
  logic                     unused_addr;

  // Register map: word 0 PRESCALE, word 1 STATUS, then one 16-byte block per channel
  assign widx      = wb_addr_i[7:2];
  assign grp       = widx[5:2];
  assign sub       = widx[1:0];
  assign ch_idx    = grp - 4'd1;
  assign ch_ok     = (grp != 4'd0) && ({1'b0, ch_idx} < 5'(NUM_CH));
  assign access    = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign wr        = access & wb_we_i;
  assign wr_pre    = wr && (widx == 6'd0);
  assign wr_status = wr && (widx == 6'd1);
  assign tick      = (pcnt == prescale);

  always_comb begin
    wmask = '0;
    for (int b = 0; b < WB_SEL_WIDTH; b++) wmask[8*b +: 8] = {8{wb_sel_i[b]}};
  end

  function automatic logic [WB_DATA_WIDTH-1:0] merge(input logic [WB_DATA_WIDTH-1:0] old);
    return (old & ~wmask) | (wb_data_i & wmask);
  endfunction

  // Hardware next-state first; byte-lane writes are merged on top so software wins
  always_comb begin
    pre_m = PRE_WIDTH'(merge(WB_DATA_WIDTH'(prescale)));
    clr   = (wr_status && wb_sel_i[0]) ? wb_data_i[NUM_CH-1:0] : '0;
    for (int n = 0; n < NUM_CH; n++) begin
      match[n]   = tick & en[n] & (cnt[n] == cmp[n]);
      en_hw[n]   = en[n] & ~(match[n] & ~periodic[n]);
      cnt_hw[n]  = (tick && en[n]) ? (match[n] ? '0 : cnt[n] + CNT_WIDTH'(1)) : cnt[n];
      wr_ctrl[n] = wr && ch_ok && (ch_idx == 4'(n)) && (sub == 2'd0);
      wr_cmp[n]  = wr && ch_ok && (ch_idx == 4'(n)) && (sub == 2'd1);
      wr_cnt[n]  = wr && ch_ok && (ch_idx == 4'(n)) && (sub == 2'd2);
      cmp_m[n]   = CNT_WIDTH'(merge(WB_DATA_WIDTH'(cmp[n])));
      cnt_m[n]   = CNT_WIDTH'(merge(WB_DATA_WIDTH'(cnt_hw[n])));
    end
  end

  always_comb begin
    rdata = '0;
    if (widx == 6'd0) rdata = WB_DATA_WIDTH'(prescale);
    else if (widx == 6'd1) rdata = WB_DATA_WIDTH'(pend);
    else if (ch_ok) begin
      for (int n = 0; n < NUM_CH; n++) begin
        if (ch_idx == 4'(n)) begin
          case (sub)
            2'd0:    rdata = WB_DATA_WIDTH'({ie[n], periodic[n], en[n]});
            2'd1:    rdata = WB_DATA_WIDTH'(cmp[n]);
            2'd2:    rdata = WB_DATA_WIDTH'(cnt[n]);
            default: rdata = '0;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wb_ack_o  <= 1'b0;
      wb_data_o <= '0;
      prescale  <= '0;
      pcnt      <= '0;
      en        <= '0;
      periodic  <= '0;
      ie        <= '0;
      pend      <= '0;
      for (int n = 0; n < NUM_CH; n++) begin
        cmp[n] <= '0;
        cnt[n] <= '0;
      end
    end else begin
      wb_ack_o  <= access;
      wb_data_o <= (access && !wb_we_i) ? rdata : '0;
      if (wr_pre) begin
        prescale <= pre_m;
        pcnt     <= '0;
      end else begin
        pcnt <= tick ? '0 : pcnt + PRE_WIDTH'(1);
      end
      // A new match outranks a simultaneous write-1-to-clear
      pend <= (pend & ~clr) | match;
      for (int n = 0; n < NUM_CH; n++) begin
        if (wr_ctrl[n] && wb_sel_i[0]) begin
          en[n]       <= wb_data_i[0];
          periodic[n] <= wb_data_i[1];
          ie[n]       <= wb_data_i[2];
        end else begin
          en[n] <= en_hw[n];
        end
        if (wr_cmp[n]) cmp[n] <= cmp_m[n];
        cnt[n] <= wr_cnt[n] ? cnt_m[n] : cnt_hw[n];
      end
    end
  end

  assign ch_irq_o    = pend & ie;
  assign timer_irq_o = |ch_irq_o;
  assign unused_addr = ^{wb_addr_i[WB_ADDR_WIDTH-1:8], wb_addr_i[1:0]};

endmodule
